// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard controller for the five-stage MIPS pipeline. Decides EX and
// ID forwarding selects, load-use / branch / jr stalls, jump squashes, and
// runs a RUN -> DRAIN -> HALT machine that retires the end instruction and
// then freezes the pipeline.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   RsD, RtD                  ID source registers
//   RsE, RtE                  EX source registers
//   WriteRegE/M/W             destination register per stage
//   RegWriteE/M/W             write enable per stage
//   MemReadE, MemReadM        load in EX / MEM
//   BranchD, JumpD, JrD, EndD decoded ID instruction class
//   EndW                      end instruction reached WB
//   stallF, stallD, flushE    pipeline register controls
//   jumpFlush, jrFlush        squash the fetched instruction
//   JrHaz                     jr operand not ready
//   ForwardAE/BE              EX select: 00 regfile, 01 WB, 10 MEM
//   ForwardAD/BD              ID compare operand from MEM ALUOut
//   halted, drainErr          frozen after end / drain timed out
//   stallCnt, flushCnt        performance counters
//
// Optional feature: define PPCTRL_PERF_EN to build the saturating stall and
// flush counters; otherwise both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int DRAIN_TIMEOUT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReadE,
  input  logic        MemReadM,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        JrD,
  input  logic        EndD,
  input  logic        EndW,
  output logic        stallF,
  output logic        stallD,
  output logic        flushE,
  output logic        jumpFlush,
  output logic        jrFlush,
  output logic        JrHaz,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        halted,
  output logic        drainErr,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  localparam logic [3:0] TIMEOUT_C = 4'(DRAIN_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] drainCnt_q, drainCnt_d;
  logic       halted_q, halted_d;
  logic       drainErr_q, drainErr_d;
  logic       lwStall, brStall, hz;

  // Register 0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic regMatch(input logic [4:0] a, input logic en,
                                    input logic [4:0] w);
    return en && (w != 5'd0) && (w == a);
  endfunction

  // Results not yet readable from MEM ALUOut in ID: anything still in EX,
  // or a load sitting in MEM.
  function automatic logic depD(input logic [4:0] r);
    return regMatch(r, RegWriteE, WriteRegE) || regMatch(r, MemReadM, WriteRegM);
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (regMatch(RsE, RegWriteM, WriteRegM))      ForwardAE = 2'b10;
    else if (regMatch(RsE, RegWriteW, WriteRegW)) ForwardAE = 2'b01;
    if (regMatch(RtE, RegWriteM, WriteRegM))      ForwardBE = 2'b10;
    else if (regMatch(RtE, RegWriteW, WriteRegW)) ForwardBE = 2'b01;
    ForwardAD = regMatch(RsD, RegWriteM, WriteRegM);
    ForwardBD = regMatch(RtD, RegWriteM, WriteRegM);
  end

  always_comb begin
    lwStall = MemReadE && (WriteRegE != 5'd0) &&
              ((WriteRegE == RsD) || (WriteRegE == RtD));
    brStall = BranchD && (depD(RsD) || depD(RtD));
    JrHaz   = JrD && depD(RsD);
    hz      = lwStall || brStall || JrHaz;
  end

  // EndW wins over the timeout, so a drain that finishes on the last allowed
  // cycle is not flagged as an error.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    halted_d   = halted_q;
    drainErr_d = drainErr_q;
    stallF     = 1'b1;
    stallD     = 1'b1;
    flushE     = 1'b1;
    jumpFlush  = 1'b0;
    jrFlush    = 1'b0;
    case (state_q)
      RUN: begin
        stallF     = hz;
        stallD     = hz;
        flushE     = hz;
        jumpFlush  = JumpD && !hz;
        jrFlush    = JrD;
        drainCnt_d = 4'd0;
        if (EndD && !hz) state_d = DRAIN;
      end
      DRAIN: begin
        drainCnt_d = drainCnt_q + 4'd1;
        if (EndW) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (drainCnt_d == TIMEOUT_C) begin
          state_d    = HALT;
          halted_d   = 1'b1;
          drainErr_d = 1'b1;
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      drainCnt_q <= 4'd0;
      halted_q   <= 1'b0;
      drainErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      halted_q   <= halted_d;
      drainErr_q <= drainErr_d;
    end
  end

  assign halted   = halted_q;
  assign drainErr = drainErr_q;

`ifdef PPCTRL_PERF_EN
  logic [31:0] stallCnt_q, flushCnt_q;

  // Counters only advance in RUN, so drain/halt stalls are not counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else if (state_q == RUN) begin
      if (stallD && (stallCnt_q != 32'hFFFF_FFFF))
        stallCnt_q <= stallCnt_q + 32'd1;
      if ((flushE || jumpFlush || jrFlush) && (flushCnt_q != 32'hFFFF_FFFF))
        flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign stallCnt = stallCnt_q;
  assign flushCnt = flushCnt_q;
`else
  assign stallCnt = 32'd0;
  assign flushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scoreboard bench for pipeline_hazard_ctrl: each cycle the expected outputs
// from a reference model are queued when inputs are driven and popped and
// compared once the DUT outputs have settled.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int TO = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM;
  logic        BranchD, JumpD, JrD, EndD, EndW;
  logic        stallF, stallD, flushE, jumpFlush, jrFlush, JrHaz;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD, halted, drainErr;
  logic [31:0] stallCnt, flushCnt;

  pipeline_hazard_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .MemReadM(MemReadM),
    .BranchD(BranchD), .JumpD(JumpD), .JrD(JrD), .EndD(EndD), .EndW(EndW),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .jumpFlush(jumpFlush), .jrFlush(jrFlush), .JrHaz(JrHaz),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .halted(halted), .drainErr(drainErr),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] vec;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: 0 RUN, 1 DRAIN, 2 HALT
  int          mState = 0;
  int          mCnt   = 0;
  logic        mHalted = 1'b0;
  logic        mErr    = 1'b0;
  logic [31:0] mStall  = '0;
  logic [31:0] mFlush  = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic mMatch(input logic [4:0] a, input logic en,
                                  input logic [4:0] w);
    return en && (w != 5'd0) && (w == a);
  endfunction

  function automatic logic mDep(input logic [4:0] r);
    return mMatch(r, RegWriteE, WriteRegE) || mMatch(r, MemReadM, WriteRegM);
  endfunction

  task automatic clearInputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM} = '0;
    {BranchD, JumpD, JrD, EndD, EndW} = '0;
  endtask

  // Called with inputs already driven, shortly after a rising edge.
  task automatic applyStimulus(input string tag);
    exp_t        e, got;
    logic        lw, br, jh, hz, st, jf, jrf;
    logic [1:0]  fa, fb;
    int          nState, nCnt;
    logic        nHalted, nErr;
    logic [31:0] nStall, nFlush;

    lw = MemReadE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    br = BranchD && (mDep(RsD) || mDep(RtD));
    jh = JrD && mDep(RsD);
    hz = lw || br || jh;
    fa = mMatch(RsE, RegWriteM, WriteRegM) ? 2'b10 :
         mMatch(RsE, RegWriteW, WriteRegW) ? 2'b01 : 2'b00;
    fb = mMatch(RtE, RegWriteM, WriteRegM) ? 2'b10 :
         mMatch(RtE, RegWriteW, WriteRegW) ? 2'b01 : 2'b00;
    st  = (mState == 0) ? hz : 1'b1;
    jf  = (mState == 0) ? (JumpD && !hz) : 1'b0;
    jrf = (mState == 0) ? JrD : 1'b0;

    e.tag = tag;
    e.vec = {18'd0, st, st, st, jf, jrf, jh, fa, fb,
             mMatch(RsD, RegWriteM, WriteRegM), mMatch(RtD, RegWriteM, WriteRegM),
             mHalted, mErr};
    e.sc  = mStall;
    e.fc  = mFlush;
    sb.push_back(e);

    #1;
    got = sb.pop_front();
    checkOutput({got.tag, ".outs"},
                {18'd0, stallF, stallD, flushE, jumpFlush, jrFlush, JrHaz,
                 ForwardAE, ForwardBE, ForwardAD, ForwardBD, halted, drainErr},
                got.vec);
    checkOutput({got.tag, ".stallCnt"}, stallCnt, got.sc);
    checkOutput({got.tag, ".flushCnt"}, flushCnt, got.fc);

    nState = mState; nCnt = mCnt; nHalted = mHalted; nErr = mErr;
    nStall = mStall; nFlush = mFlush;
    if (!rst) begin
      nState = 0; nCnt = 0; nHalted = 0; nErr = 0; nStall = 0; nFlush = 0;
    end else begin
      case (mState)
        0: begin
          nCnt = 0;
          if (EndD && !hz) nState = 1;
`ifdef PPCTRL_PERF_EN
          if (hz && mStall != 32'hFFFF_FFFF) nStall = mStall + 1;
          if ((hz || jf || jrf) && mFlush != 32'hFFFF_FFFF) nFlush = mFlush + 1;
`endif
        end
        1: begin
          nCnt = mCnt + 1;
          if (EndW) begin
            nState = 2; nHalted = 1;
          end else if (nCnt == TO) begin
            nState = 2; nHalted = 1; nErr = 1;
          end
        end
        default: ;
      endcase
    end

    @(posedge clk);
    #1;
    mState = nState; mCnt = nCnt; mHalted = nHalted; mErr = nErr;
    mStall = nStall; mFlush = nFlush;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b0;
    applyStimulus("reset");
    rst = 1'b1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("resetState");
    rst = 1'b1;

    // Three load-use sequences: stall, bubble/lw in MEM, WB forward
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      MemReadE = 1; RegWriteE = 1; WriteRegE = 5'd2; RsD = 5'd2;
      applyStimulus("lwStall");
      clearInputs();
      MemReadM = 1; RegWriteM = 1; WriteRegM = 5'd2; RsD = 5'd2;
      applyStimulus("lwInMem");
      clearInputs();
      RegWriteW = 1; WriteRegW = 5'd2; RsE = 5'd2;
      applyStimulus("lwFwdWB");
    end

    clearInputs();
    RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd5;
    RsE = 5'd5; RtE = 5'd5;
    applyStimulus("memWins");

    clearInputs();
    RegWriteM = 1; WriteRegM = 5'd0; RsE = 5'd0; RegWriteW = 1; WriteRegW = 5'd0;
    applyStimulus("reg0NoFwd");

    clearInputs();
    MemReadE = 1; WriteRegE = 5'd0; RsD = 5'd0; RtD = 5'd0; BranchD = 1;
    applyStimulus("reg0NoStall");

    clearInputs();
    JrD = 1; RsD = 5'd31; RegWriteE = 1; WriteRegE = 5'd31;
    applyStimulus("jrHaz");
    clearInputs();
    JrD = 1; RsD = 5'd31; RegWriteM = 1; WriteRegM = 5'd31;
    applyStimulus("jrFwd");

    clearInputs();
    BranchD = 1; RsD = 5'd4; MemReadE = 1; RegWriteE = 1; WriteRegE = 5'd4;
    applyStimulus("brLoadE");
    clearInputs();
    BranchD = 1; RsD = 5'd4; MemReadM = 1; RegWriteM = 1; WriteRegM = 5'd4;
    applyStimulus("brLoadM");
    clearInputs();
    BranchD = 1; RsD = 5'd4; RegWriteW = 1; WriteRegW = 5'd4;
    applyStimulus("brClear");

    clearInputs();
    JumpD = 1;
    applyStimulus("jump");
    clearInputs();
    JumpD = 1; MemReadE = 1; WriteRegE = 5'd7; RtD = 5'd7;
    applyStimulus("jumpHeld");

    // Random RUN-mode traffic over a small register set
    for (int i = 0; i < 60; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      {RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM} = 5'($urandom);
      {BranchD, JumpD, JrD} = 3'($urandom);
      EndD = 0; EndW = 0;
      applyStimulus("random");
    end

    // EndD under a hazard is held, then accepted; EndW after two cycles
    clearInputs();
    EndD = 1; MemReadE = 1; WriteRegE = 5'd3; RsD = 5'd3;
    applyStimulus("endHeld");
    clearInputs();
    EndD = 1;
    applyStimulus("endAccept");
    clearInputs();
    applyStimulus("drain1");
    applyStimulus("drain2");
    EndW = 1;
    applyStimulus("drainEndW");
    clearInputs();
    JumpD = 1; JrD = 1;
    repeat (3) applyStimulus("halt");
    doReset();
    applyStimulus("afterReset");

    // EndW never arrives: forced halt with error
    clearInputs();
    EndD = 1;
    applyStimulus("endAcceptTO");
    clearInputs();
    for (int i = 0; i < TO + 3; i++) applyStimulus("timeout");
    doReset();

    // EndW on the very cycle the timeout would fire
    clearInputs();
    EndD = 1;
    applyStimulus("endAcceptTie");
    clearInputs();
    for (int i = 0; i < TO + 2; i++) begin
      EndW = (i == TO - 1);
      applyStimulus("tie");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
